instr_fetch: RTL and testbench

Fetch stage of the five-stage MIPS core. Owns the PC register and drives the instruction-SRAM read port. Presents each fetched instruction together with its PC and PC+4 to the IF/ID pipeline register. Handles stall, branch redirect (held pending across stalls), pipeline flush (exception/ERET) and address-error detection.

---
 rtl/instr_fetch_pkg.sv | 23 ++
 rtl/fetch_npc_sel.sv | 55 +++++
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants, npc source encoding and helpers for the fetch stage.
package instr_fetch_pkg;

    localparam int unsigned PCSIZE      = 32;
    localparam int unsigned INSTRLENGTH = 32;
    localparam logic [31:0] ZEROWORD    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC     = 32'hBFC0_0380;

    typedef enum logic [2:0] {
        NpcReset,
        NpcFlush,
        NpcStall,
        NpcPend,
        NpcBranch,
        NpcSeq
    } npc_sel_e;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_npc_sel.sv
// Priority mux selecting the next fetch address and the pending-redirect set/clear strobes.
module fetch_npc_sel
    import instr_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic              i_pcsrc,
    input  logic [ADDR_W-1:0] i_pc_branch,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_flush_pc,
    input  logic [ADDR_W-1:0] i_pcf,
    input  logic              i_pend_v,
    input  logic [ADDR_W-1:0] i_pend_pc,
    output logic [ADDR_W-1:0] o_npc,
    output logic              o_pend_set,
    output logic              o_pend_clr
);

    npc_sel_e w_sel;

    always_comb begin
        w_sel = NpcSeq;
        if (i_reset) begin
            w_sel = NpcReset;
        end else if (i_flush) begin
            w_sel = NpcFlush;
        end else if (i_stall) begin
            w_sel = NpcStall;
        end else if (i_pend_v) begin
            w_sel = NpcPend;
        end else if (i_pcsrc) begin
            w_sel = NpcBranch;
        end
    end

    always_comb begin
        o_npc = i_pcf + ADDR_W'(4);
        unique case (w_sel)
            NpcReset:  o_npc = RESET_PC;
            NpcFlush:  o_npc = i_flush_pc;
            NpcStall:  o_npc = i_pcf;
            NpcPend:   o_npc = i_pend_pc;
            NpcBranch: o_npc = i_pc_branch;
            default:   o_npc = i_pcf + ADDR_W'(4);
        endcase
    end

    // A redirect resolved during a stall is parked until the stall lifts.
    assign o_pend_set = (w_sel == NpcStall) && i_pcsrc;
    assign o_pend_clr = (w_sel == NpcFlush) || (w_sel == NpcPend);

endmodule

// File: rtl/instr_fetch.sv
// MIPS fetch stage: PC register, instruction-SRAM read port and IF/ID-facing outputs.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              StallF,
    input  logic              PCSrcD,
    input  logic [ADDR_W-1:0] PCBranchD,
    input  logic              FlushF,
    input  logic [ADDR_W-1:0] FlushPC,
    output logic              inst_sram_en,
    output logic [3:0]        inst_sram_wen,
    output logic [ADDR_W-1:0] inst_sram_addr,
    output logic [31:0]       inst_sram_wdata,
    input  logic [31:0]       inst_sram_rdata,
    output logic [31:0]       InstrF,
    output logic [ADDR_W-1:0] PCF,
    output logic [ADDR_W-1:0] PCPlus4F,
    output logic              InstrValidF,
    output logic              AdelF
);

    logic [ADDR_W-1:0] r_pcf;
    logic              r_pend_v;
    logic [ADDR_W-1:0] r_pend_pc;
    logic              r_valid;
    logic              r_adel;

    logic [ADDR_W-1:0] w_npc;
    logic              w_pend_set;
    logic              w_pend_clr;

    fetch_npc_sel #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_npc_sel (
        .i_reset     (reset),
        .i_stall     (StallF),
        .i_pcsrc     (PCSrcD),
        .i_pc_branch (PCBranchD),
        .i_flush     (FlushF),
        .i_flush_pc  (FlushPC),
        .i_pcf       (r_pcf),
        .i_pend_v    (r_pend_v),
        .i_pend_pc   (r_pend_pc),
        .o_npc       (w_npc),
        .o_pend_set  (w_pend_set),
        .o_pend_clr  (w_pend_clr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pcf     <= RESET_PC;
            r_adel    <= 1'b0;
            r_valid   <= 1'b1;
            r_pend_v  <= 1'b0;
            r_pend_pc <= '0;
        end else begin
            r_pcf   <= w_npc;
            r_adel  <= !word_aligned(w_npc[1:0]);
            r_valid <= word_aligned(w_npc[1:0]);
            if (w_pend_set) begin
                r_pend_v  <= 1'b1;
                r_pend_pc <= PCBranchD;
            end else if (w_pend_clr) begin
                r_pend_v <= 1'b0;
            end
        end
    end

    // Enable stays combinational on npc so the reset-cycle read returns RESET_PC's word.
    assign inst_sram_en    = word_aligned(w_npc[1:0]);
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = w_npc;
    assign inst_sram_wdata = ZEROWORD;

    assign InstrF      = r_valid ? inst_sram_rdata : ZEROWORD;
    assign PCF         = r_pcf;
    assign PCPlus4F    = r_pcf + ADDR_W'(4);
    assign InstrValidF = r_valid;
    assign AdelF       = r_adel;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic vs. a reference model.
module tb_instr_fetch;

    localparam logic [31:0] RST = 32'hBFC0_0000;

    logic        clock = 1'b0;
    logic        reset, StallF, PCSrcD, FlushF;
    logic [31:0] PCBranchD, FlushPC;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        InstrValidF, AdelF;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_pc, m_pend_pc, m_npc;
    logic        m_pend_v, m_valid, m_adel;

    always #5 clock = ~clock;

    // SRAM model: mem[addr] = ~addr, one-cycle read latency.
    always @(posedge clock) if (inst_sram_en) inst_sram_rdata <= ~inst_sram_addr;

    instr_fetch #(
        .ADDR_W   (32),
        .RESET_PC (RST)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .StallF          (StallF),
        .PCSrcD          (PCSrcD),
        .PCBranchD       (PCBranchD),
        .FlushF          (FlushF),
        .FlushPC         (FlushPC),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .InstrF          (InstrF),
        .PCF             (PCF),
        .PCPlus4F        (PCPlus4F),
        .InstrValidF     (InstrValidF),
        .AdelF           (AdelF)
    );

    function automatic logic [31:0] ref_npc();
        if (reset)         return RST;
        else if (FlushF)   return FlushPC;
        else if (StallF)   return m_pc;
        else if (m_pend_v) return m_pend_pc;
        else if (PCSrcD)   return PCBranchD;
        else               return m_pc + 32'd4;
    endfunction

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic step();
        m_npc = ref_npc();
        @(posedge clock);
        #1;
        if (reset) begin
            m_pend_v  = 1'b0;
            m_pend_pc = 32'h0;
        end else if (FlushF) begin
            m_pend_v = 1'b0;
        end else if (StallF) begin
            if (PCSrcD) begin
                m_pend_v  = 1'b1;
                m_pend_pc = PCBranchD;
            end
        end else begin
            m_pend_v = 1'b0;
        end
        m_pc    = m_npc;
        m_valid = (m_npc[1:0] == 2'b00);
        m_adel  = !m_valid;
    endtask

    task automatic idle_inputs();
        StallF = 0; PCSrcD = 0; FlushF = 0; PCBranchD = 0; FlushPC = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        step(); step();
        vectors++; if (PCF !== RST) begin miscompares++;
            $display("FAIL reset_pcf: got %h want %h", PCF, RST); end
        vectors++; if (InstrValidF !== 1'b1) begin miscompares++;
            $display("FAIL reset_valid: got %b want 1", InstrValidF); end
        vectors++; if (AdelF !== 1'b0) begin miscompares++;
            $display("FAIL reset_adel: got %b want 0", AdelF); end
        reset = 0;
        #1;
        vectors++; if (InstrF !== ~RST) begin miscompares++;
            $display("FAIL first_instr: got %h want %h", InstrF, ~RST); end
        vectors++; if (inst_sram_addr !== RST + 32'd4) begin miscompares++;
            $display("FAIL first_addr: got %h want %h", inst_sram_addr, RST + 32'd4); end
        vectors++; if (inst_sram_wen !== 4'b0000 || inst_sram_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL write_port: got wen=%b wdata=%h want 0", inst_sram_wen,
                     inst_sram_wdata); end
        step();
        vectors++; if (PCF !== 32'hBFC0_0004 || InstrF !== ~32'hBFC0_0004) begin miscompares++;
            $display("FAIL seq_4: got pc=%h instr=%h want BFC00004", PCF, InstrF); end
        step();
        vectors++; if (PCF !== 32'hBFC0_0008) begin miscompares++;
            $display("FAIL seq_8: got %h want BFC00008", PCF); end
    endtask

    task automatic test_stall();
        StallF = 1;
        repeat (3) begin
            #1;
            vectors++; if (inst_sram_addr !== 32'hBFC0_0008) begin miscompares++;
                $display("FAIL stall_addr: got %h want BFC00008", inst_sram_addr); end
            step();
            vectors++;
            if (PCF !== 32'hBFC0_0008 || InstrF !== ~32'hBFC0_0008 ||
                PCPlus4F !== 32'hBFC0_000C) begin
                miscompares++;
                $display("FAIL stall_hold: got pc=%h instr=%h pc4=%h want BFC00008", PCF,
                         InstrF, PCPlus4F);
            end
        end
        StallF = 0;
        step();
        vectors++; if (PCF !== 32'hBFC0_000C) begin miscompares++;
            $display("FAIL stall_resume: got %h want BFC0000C", PCF); end
    endtask

    task automatic test_branch();
        PCSrcD = 1; PCBranchD = 32'hBFC0_0100;
        step();
        PCSrcD = 0;
        vectors++; if (PCF !== 32'hBFC0_0100) begin miscompares++;
            $display("FAIL branch_tgt: got %h want BFC00100", PCF); end
        step();
        vectors++; if (PCF !== 32'hBFC0_0104) begin miscompares++;
            $display("FAIL branch_seq: got %h want BFC00104", PCF); end
    endtask

    task automatic test_pending_branch();
        StallF = 1; PCSrcD = 1; PCBranchD = 32'hBFC0_0200;
        step();
        PCSrcD = 0;
        vectors++; if (PCF !== 32'hBFC0_0104) begin miscompares++;
            $display("FAIL pend_hold1: got %h want BFC00104", PCF); end
        step();
        vectors++; if (PCF !== 32'hBFC0_0104) begin miscompares++;
            $display("FAIL pend_hold2: got %h want BFC00104", PCF); end
        StallF = 0;
        step();
        vectors++; if (PCF !== 32'hBFC0_0200) begin miscompares++;
            $display("FAIL pend_taken: got %h want BFC00200", PCF); end
    endtask

    task automatic test_flush();
        StallF = 1; PCSrcD = 1; PCBranchD = 32'hBFC0_0300;
        step();
        PCSrcD = 0; FlushF = 1; FlushPC = 32'hBFC0_0380;
        step();
        vectors++; if (PCF !== 32'hBFC0_0380) begin miscompares++;
            $display("FAIL flush_tgt: got %h want BFC00380", PCF); end
        FlushF = 0; StallF = 0;
        step();
        vectors++; if (PCF !== 32'hBFC0_0384) begin miscompares++;
            $display("FAIL flush_drops_pend: got %h want BFC00384", PCF); end
    endtask

    task automatic test_misaligned();
        PCSrcD = 1; PCBranchD = 32'hBFC0_0102;
        #1;
        vectors++; if (inst_sram_en !== 1'b0) begin miscompares++;
            $display("FAIL misalign_en: got %b want 0", inst_sram_en); end
        step();
        PCSrcD = 0;
        vectors++;
        if (PCF !== 32'hBFC0_0102 || AdelF !== 1'b1 || InstrValidF !== 1'b0 ||
            InstrF !== 32'h0) begin
            miscompares++;
            $display("FAIL misalign_out: got pc=%h adel=%b valid=%b instr=%h", PCF, AdelF,
                     InstrValidF, InstrF);
        end
        step();
        vectors++; if (PCF !== 32'hBFC0_0106 || AdelF !== 1'b1) begin miscompares++;
            $display("FAIL misalign_seq: got pc=%h adel=%b want BFC00106/1", PCF, AdelF); end
        PCSrcD = 1; PCBranchD = 32'hFFFF_FFFC;
        step();
        PCSrcD = 0;
        vectors++; if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0 || InstrValidF !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_top: got pc=%h pc4=%h valid=%b", PCF, PCPlus4F, InstrValidF); end
        step();
        vectors++; if (PCF !== 32'h0 || InstrF !== 32'hFFFF_FFFF) begin miscompares++;
            $display("FAIL wrap_zero: got pc=%h instr=%h want 0/FFFFFFFF", PCF, InstrF); end
    endtask

    task automatic test_reset_mid_stall();
        StallF = 1; PCSrcD = 1; PCBranchD = 32'hBFC0_0500;
        step();
        reset = 1; PCSrcD = 0;
        step();
        reset = 0; StallF = 0;
        vectors++; if (PCF !== RST) begin miscompares++;
            $display("FAIL midreset_pc: got %h want %h", PCF, RST); end
        step();
        vectors++; if (PCF !== RST + 32'd4) begin miscompares++;
            $display("FAIL midreset_pend: got %h want %h", PCF, RST + 32'd4); end
    endtask

    task automatic test_random();
        logic [31:0] exp_npc;
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            FlushF    = ($urandom_range(0, 19) == 0);
            StallF    = ($urandom_range(0, 3) == 0);
            PCSrcD    = ($urandom_range(0, 3) == 0);
            PCBranchD = $urandom;
            if ($urandom_range(0, 7) != 0) PCBranchD[1:0] = 2'b00;
            FlushPC   = ($urandom_range(0, 1) == 0) ? 32'hBFC0_0380 : ($urandom & 32'hFFFF_FFFC);
            #1;
            exp_npc = ref_npc();
            vectors++;
            if (inst_sram_addr !== exp_npc || inst_sram_en !== (exp_npc[1:0] == 2'b00)) begin
                miscompares++;
                $display("FAIL rand_addr[%0d]: got addr=%h en=%b want %h", i, inst_sram_addr,
                         inst_sram_en, exp_npc);
            end
            step();
            vectors++;
            if (PCF !== m_pc || PCPlus4F !== m_pc + 32'd4 || InstrValidF !== m_valid ||
                AdelF !== m_adel || InstrF !== (m_valid ? ~m_pc : 32'h0)) begin
                miscompares++;
                $display("FAIL rand_out[%0d]: got pc=%h pc4=%h v=%b a=%b i=%h want pc=%h v=%b",
                         i, PCF, PCPlus4F, InstrValidF, AdelF, InstrF, m_pc, m_valid);
            end
        end
        idle_inputs();
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_pending_branch();
        test_flush();
        test_misaligned();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
